// File: rtl/win_tile_tracker.sv
// win_tile_tracker
//   Upstream stage of the window-burst write controller. It takes a raster
//   pixel stream of IMG_W x IMG_H pixels and forwards each pixel through a
//   one-deep registered slice. Each pixel is tagged with the WIN x WIN tile it
//   belongs to. win_last marks the final pixel of each tile; downstream uses
//   that pulse to launch the burst for the completed tile.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   in_data       input pixel
//   in_valid      input pixel valid
//   in_sof        first pixel of frame (qualified by in_valid)
//   in_ready      slice can take a pixel this cycle (combinational)
//   out_data      registered pixel
//   out_valid     out_data valid
//   out_ready     downstream accepts
//   tile_x/tile_y tile column/row of out_data
//   win_last      out_data closes tile (tile_x, tile_y)
//   frame_last    out_data is the last pixel of the frame
//   sof_err       one-cycle pulse: in_sof accepted away from position (0,0)
module win_tile_tracker #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 36,
  parameter int IMG_H  = 36,
  parameter int WIN    = 6,
  localparam int NTX   = IMG_W / WIN,
  localparam int NTY   = IMG_H / WIN,
  localparam int TX_W  = (NTX > 1) ? $clog2(NTX) : 1,
  localparam int TY_W  = (NTY > 1) ? $clog2(NTY) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TX_W-1:0]   tile_x,
  output logic [TY_W-1:0]   tile_y,
  output logic              win_last,
  output logic              frame_last,
  output logic              sof_err
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CW-1:0]   IN_TILE_MAX = CW'(WIN - 1);
  localparam logic [TX_W-1:0] TX_MAX      = TX_W'(NTX - 1);
  localparam logic [TY_W-1:0] TY_MAX      = TY_W'(NTY - 1);

  typedef enum logic {IDLE, FULL} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [TX_W-1:0]     tile_x_q;
  logic [TY_W-1:0]     tile_y_q;
  logic                win_last_q;
  logic                frame_last_q;
  logic                sof_err_q;

  // Position of the next pixel to be accepted, kept as tile plus offset
  // inside the tile so no divider is needed.
  logic [CW-1:0]       cit_q, rit_q, cit_d, rit_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic [TY_W-1:0]     ty_q, ty_d;

  // Position actually assigned to the pixel being accepted (SOF forces origin).
  logic [CW-1:0]       pcit, prit;
  logic [TX_W-1:0]     ptx;
  logic [TY_W-1:0]     pty;
  logic                at_origin;
  logic                pos_wl, pos_fl;
  logic                accept, transfer;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  assign out_data   = out_data_q;
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign win_last   = win_last_q;
  assign frame_last = frame_last_q;
  assign sof_err    = sof_err_q;

  assign at_origin = (cit_q == '0) && (rit_q == '0) && (tx_q == '0) && (ty_q == '0);

  always_comb begin
    pcit = cit_q;
    prit = rit_q;
    ptx  = tx_q;
    pty  = ty_q;
    if (in_sof) begin
      pcit = '0;
      prit = '0;
      ptx  = '0;
      pty  = '0;
    end

    pos_wl = (pcit == IN_TILE_MAX) && (prit == IN_TILE_MAX);
    pos_fl = pos_wl && (ptx == TX_MAX) && (pty == TY_MAX);

    // Raster advance from the assigned position: column within tile, then
    // tile column; at end of line, row within tile, then tile row.
    cit_d = pcit;
    rit_d = prit;
    tx_d  = ptx;
    ty_d  = pty;
    if (pcit != IN_TILE_MAX) begin
      cit_d = pcit + 1'b1;
    end else begin
      cit_d = '0;
      if (ptx != TX_MAX) begin
        tx_d = ptx + 1'b1;
      end else begin
        tx_d = '0;
        if (prit != IN_TILE_MAX) begin
          rit_d = prit + 1'b1;
        end else begin
          rit_d = '0;
          if (pty != TY_MAX) ty_d = pty + 1'b1;
          else               ty_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_data_q   <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      win_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      sof_err_q    <= 1'b0;
      cit_q        <= '0;
      rit_q        <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= FULL;
        FULL:    if (transfer && !accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        out_data_q   <= in_data;
        tile_x_q     <= ptx;
        tile_y_q     <= pty;
        win_last_q   <= pos_wl;
        frame_last_q <= pos_fl;
        cit_q        <= cit_d;
        rit_q        <= rit_d;
        tx_q         <= tx_d;
        ty_q         <= ty_d;
      end

      // Resync at origin is legal; anywhere else it is flagged once.
      sof_err_q <= accept && in_sof && !at_origin;
    end
  end

endmodule
